// File: rtl/bc_msg_arbiter_pkg.sv
// Shared definitions for the broadcast-message path between riscv_blocks
// and bc_msg_arbiter.
//   - BC_MSG_WIDTH: message width derived from the broadcast region size
//   - field offsets of data / strobe / word address inside a message
//   - bc_msg_pack: helper that assembles a message from its fields
package bc_msg_arbiter_pkg;

    localparam int unsigned BC_REGION_SIZE = 4096;  // bytes
    localparam int unsigned BC_ADDR_W      = $clog2(BC_REGION_SIZE) - 2;  // word address
    localparam int unsigned BC_MSG_WIDTH   = 32 + 4 + BC_ADDR_W;

    localparam int unsigned BC_DATA_LSB = 0;
    localparam int unsigned BC_DATA_W   = 32;
    localparam int unsigned BC_STRB_LSB = 32;
    localparam int unsigned BC_STRB_W   = 4;
    localparam int unsigned BC_ADDR_LSB = 36;

    typedef logic [BC_MSG_WIDTH-1:0] bc_msg_t;

    function automatic bc_msg_t bc_msg_pack(input logic [BC_ADDR_W-1:0] addr,
                                            input logic [BC_STRB_W-1:0] strb,
                                            input logic [BC_DATA_W-1:0] data);
        return {addr, strb, data};
    endfunction

endpackage

// File: rtl/bc_msg_fifo.sv
// Single-clock FIFO with occupancy count, used once per core to buffer
// broadcast messages ahead of the arbiter.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry, valid the cycle after its push
//   count      : registered number of stored entries
//   full/empty : derived from count only
module bc_msg_fifo #(
    parameter int unsigned WIDTH = 46,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned AW    = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/bc_msg_arbiter.sv
// Round-robin arbiter that collects broadcast messages from every
// riscv_block and fans one message per cycle back out to all of them.
//   clk, rst           : clock, synchronous active-high reset
//   core_msg_in        : per-core message, core i at [i*MSG_WIDTH +: MSG_WIDTH]
//   core_msg_in_valid  : per-core valid
//   core_msg_in_ready  : per-core ready (FIFO not full, 0 during rst)
//   bc_msg_out         : broadcast message, holds when not valid
//   bc_msg_out_valid   : broadcast valid, no backpressure
//   fifo_occupancy_max : high-water mark of all per-core FIFO counts
module bc_msg_arbiter
    import bc_msg_arbiter_pkg::*;
#(
    parameter int unsigned CORE_COUNT  = 16,
    parameter int unsigned MSG_WIDTH   = BC_MSG_WIDTH,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned PIPE_STAGES = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CORE_COUNT*MSG_WIDTH-1:0] core_msg_in,
    input  logic [CORE_COUNT-1:0]           core_msg_in_valid,
    output logic [CORE_COUNT-1:0]           core_msg_in_ready,
    output logic [MSG_WIDTH-1:0]            bc_msg_out,
    output logic                            bc_msg_out_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_occupancy_max
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

    logic [CORE_COUNT-1:0] fifo_full;
    logic [CORE_COUNT-1:0] fifo_empty;
    logic [CORE_COUNT-1:0] push;
    logic [CORE_COUNT-1:0] grant;
    logic [MSG_WIDTH-1:0]  head  [CORE_COUNT];
    logic [CNT_W-1:0]      count [CORE_COUNT];

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_any;
    logic [CNT_W-1:0]      count_max;

    // Stage 0 is the arbiter output register; stages 1..PIPE_STAGES are
    // extra fan-out registers.
    logic [MSG_WIDTH-1:0]  pipe_msg [PIPE_STAGES+1];
    logic [PIPE_STAGES:0]  pipe_valid;

    // Ready comes from the registered count only, so a pop on a full FIFO
    // does not reopen it in the same cycle.
    assign core_msg_in_ready = rst ? '0 : ~fifo_full;
    assign push              = core_msg_in_valid & core_msg_in_ready;

    for (genvar i = 0; i < CORE_COUNT; i++) begin : g_fifo
        bc_msg_fifo #(
            .WIDTH (MSG_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[i]),
            .push_data (core_msg_in[i*MSG_WIDTH +: MSG_WIDTH]),
            .pop       (grant[i]),
            .head      (head[i]),
            .count     (count[i]),
            .full      (fifo_full[i]),
            .empty     (fifo_empty[i])
        );
    end

    // First non-empty FIFO scanning upward from rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < CORE_COUNT; k++) begin
            idx = (32'(rr_ptr) + k) % CORE_COUNT;
            if (!grant_any && !fifo_empty[idx]) begin
                grant_any      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        count_max = '0;
        for (int unsigned i = 0; i < CORE_COUNT; i++) begin
            if (count[i] > count_max) count_max = count[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr             <= '0;
            pipe_valid         <= '0;
            fifo_occupancy_max <= '0;
            for (int unsigned k = 0; k < PIPE_STAGES + 1; k++) begin
                pipe_msg[k] <= '0;
            end
        end else begin
            pipe_valid[0] <= grant_any;
            if (grant_any) begin
                rr_ptr      <= PTR_W'((32'(grant_idx) + 1) % CORE_COUNT);
                pipe_msg[0] <= head[grant_idx];
            end
            // Later stages only load on valid so the output holds its last message.
            for (int unsigned k = 1; k < PIPE_STAGES + 1; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                if (pipe_valid[k-1]) pipe_msg[k] <= pipe_msg[k-1];
            end
            if (count_max > fifo_occupancy_max) fifo_occupancy_max <= count_max;
        end
    end

    assign bc_msg_out       = pipe_msg[PIPE_STAGES];
    assign bc_msg_out_valid = pipe_valid[PIPE_STAGES];

endmodule
